// File: rtl/pixel_pkg.sv
// pixel_pkg
// Shared definitions for the pixel FIFO write path: default pixel width,
// FIFO depth and the write-arbiter state encoding.
package pixel_pkg;

    localparam int PIX_W_DEFAULT = 8;
    localparam int FIFO_DEPTH    = 16;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// rr_pick
// Combinational round-robin priority picker. Scans req starting at last+1
// (modulo NUM_REQ) and returns the first set bit.
// Ports:
//   req     - request vector, one bit per producer
//   last    - index of the previous winner (scan starts one past it)
//   gnt     - one-hot grant (zero when no request)
//   gnt_idx - index of the granted bit (zero when no request)
//   valid   - at least one request is present
module rr_pick #(
    parameter int NUM_REQ = 4
) (
    input  logic [NUM_REQ-1:0]         req,
    input  logic [$clog2(NUM_REQ)-1:0] last,
    output logic [NUM_REQ-1:0]         gnt,
    output logic [$clog2(NUM_REQ)-1:0] gnt_idx,
    output logic                       valid
);

    localparam int ID_W = $clog2(NUM_REQ);

    logic found;
    int   pos;

    assign valid = |req;

    // NOTE: every variable written here gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        gnt     = '0;
        gnt_idx = '0;
        found   = 1'b0;
        pos     = 0;
        // Offsets 1..NUM_REQ visit last+1 first and last itself at the end,
        // so the previous winner has the lowest priority.
        for (int i = 1; i <= NUM_REQ; i++) begin
            pos = int'(last) + i;
            if (pos >= NUM_REQ) begin
                pos = pos - NUM_REQ;
            end
            if (!found && req[pos]) begin
                found    = 1'b1;
                gnt[pos] = 1'b1;
                gnt_idx  = ID_W'(pos);
            end
        end
    end

endmodule

// File: rtl/pixel_fifo_wr_arbiter.sv
// pixel_fifo_wr_arbiter
// Round-robin write arbiter sharing the pixel FIFO write port between
// NUM_REQ producers. One producer owns the port for a burst of up to
// BURST_LEN pixels; the owner is stalled (grant held) while the FIFO is full.
// Ports:
//   clk, rst_n     - clock, synchronous active-low reset
//   req, pix_in    - per-producer valid and pixel (producer i at [i*PIX_W +: PIX_W])
//   rdy            - per-producer accept; pixel taken when rdy[i] & req[i]
//   fifo_full      - FIFO full, stalls writes
//   fifo_overflow  - FIFO overflow indication, latched into err_ovf
//   wr, inputpixel - FIFO write strobe and data
//   gnt_id         - current or last owner
//   busy           - burst in progress
//   burst_done     - one-cycle pulse in the cycle after a burst ends
//   err_ovf        - sticky overflow flag, cleared only by reset
module pixel_fifo_wr_arbiter
    import pixel_pkg::*;
#(
    parameter int NUM_REQ   = 4,
    parameter int PIX_W     = PIX_W_DEFAULT,
    parameter int BURST_LEN = 8
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*PIX_W-1:0]   pix_in,
    output logic [NUM_REQ-1:0]         rdy,
    input  logic                       fifo_full,
    input  logic                       fifo_overflow,
    output logic                       wr,
    output logic [PIX_W-1:0]           inputpixel,
    output logic [$clog2(NUM_REQ)-1:0] gnt_id,
    output logic                       busy,
    output logic                       burst_done,
    output logic                       err_ovf
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);
    // A burst longer than the FIFO could never drain in one go; clamp to it.
    localparam int BURST_CAP = (BURST_LEN > FIFO_DEPTH) ? FIFO_DEPTH : BURST_LEN;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BURST_CAP - 1);

    arb_state_t          state_q, state_d;
    logic [NUM_REQ-1:0]  gnt_q, gnt_d;
    logic [ID_W-1:0]     gnt_id_q, gnt_id_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [ID_W-1:0]     last_q, last_d;
    logic                burst_done_q, burst_done_d;
    logic                err_ovf_q, err_ovf_d;

    logic [NUM_REQ-1:0]  pick_gnt;
    logic [ID_W-1:0]     pick_idx;
    logic                pick_valid;
    logic                owner_req;
    logic [PIX_W-1:0]    owner_pix;

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .req     (req),
        .last    (last_q),
        .gnt     (pick_gnt),
        .gnt_idx (pick_idx),
        .valid   (pick_valid)
    );

    assign owner_req = |(gnt_q & req);
    assign owner_pix = pix_in[gnt_id_q*PIX_W +: PIX_W];

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: reset is sampled at the clock edge (synchronous), and all state
    // uses non-blocking assignments so every flop sees pre-edge values.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            gnt_q        <= '0;
            gnt_id_q     <= '0;
            cnt_q        <= '0;
            last_q       <= ID_W'(NUM_REQ - 1);  // producer 0 wins first
            burst_done_q <= 1'b0;
            err_ovf_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            gnt_q        <= gnt_d;
            gnt_id_q     <= gnt_id_d;
            cnt_q        <= cnt_d;
            last_q       <= last_d;
            burst_done_q <= burst_done_d;
            err_ovf_q    <= err_ovf_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        gnt_d        = gnt_q;
        gnt_id_d     = gnt_id_q;
        cnt_d        = cnt_q;
        last_d       = last_q;
        burst_done_d = 1'b0;
        err_ovf_d    = err_ovf_q | fifo_overflow;

        case (state_q)
            IDLE: begin
                if (pick_valid && !fifo_full) begin
                    state_d  = BURST;
                    gnt_d    = pick_gnt;
                    gnt_id_d = pick_idx;
                    cnt_d    = '0;
                    last_d   = pick_idx;
                end
            end
            BURST: begin
                if (wr) begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
                // Release on the final beat, or when the owner goes quiet
                // while the FIFO could accept; a full FIFO alone holds the grant.
                if ((wr && cnt_q == CNT_LAST) || (!owner_req && !fifo_full)) begin
                    state_d      = IDLE;
                    gnt_d        = '0;
                    burst_done_d = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs (held at zero while reset is asserted)
    // ------------------------------------------------------------------
    always_comb begin
        rdy        = '0;
        wr         = 1'b0;
        inputpixel = '0;
        busy       = 1'b0;
        burst_done = 1'b0;
        if (rst_n) begin
            if (state_q == BURST) begin
                rdy  = gnt_q & {NUM_REQ{~fifo_full}};
                busy = 1'b1;
            end
            wr = |(rdy & req);
            if (wr) begin
                inputpixel = owner_pix;
            end
            burst_done = burst_done_q;
        end
    end

    assign gnt_id  = gnt_id_q;
    assign err_ovf = err_ovf_q;

endmodule

// File: doc/pixel_fifo_wr_arbiter.md
# pixel_fifo_wr_arbiter

Round-robin write arbiter sharing the single 16-entry pixel FIFO (`fifo_mem`) between `NUM_REQ` pixel producers. It grants one producer at a time for a burst of up to `BURST_LEN` pixels, drives the FIFO `wr`/`inputpixel` pins, and stalls producers while the FIFO is full. It sits between the feature-map pixel sources and the FIFO write port. It also reports the current owner, burst completion and a sticky overflow error.

## Interface
Parameters:
- `NUM_REQ`, 4: number of producers, 2..8.
- `PIX_W`, 8: pixel width; must match the FIFO data width.
- `BURST_LEN`, 8: maximum pixels per grant, 1..16.

Ports:
- `clk`, in, 1: single clock; all state updates on its rising edge.
- `rst_n`, in, 1: reset, synchronous and active-low.
- `req`, in, `NUM_REQ`: producer i has a valid pixel this cycle.
- `pix_in`, in, `NUM_REQ*PIX_W`: pixel of producer i in bits [i*PIX_W +: PIX_W].
- `rdy`, out, `NUM_REQ`: producer i's pixel is accepted this cycle if `req[i]` is also high.
- `fifo_full`, in, 1: from the FIFO.
- `fifo_overflow`, in, 1: from the FIFO.
- `wr`, out, 1: FIFO write strobe.
- `inputpixel`, out, `PIX_W`: FIFO write data.
- `gnt_id`, out, `$clog2(NUM_REQ)`: index of the current or last owner.
- `busy`, out, 1: a burst is in progress (state BURST).
- `burst_done`, out, 1: one-cycle pulse when a burst ends.
- `err_ovf`, out, 1: sticky flag, set when `fifo_overflow` is seen.

## Operation
FSM states are IDLE and BURST. Registers:
- `state`
- `gnt_q` (one-hot)
- `gnt_id`
- `cnt` (`$clog2(BURST_LEN+1)` bits)
- `last` (round-robin pointer)
- `burst_done`
- `err_ovf`

IDLE:
- If `req` is nonzero and `fifo_full` is 0, pick the first set bit of `req` scanning from `last+1` modulo `NUM_REQ`.
- On that pick: load `gnt_q` and `gnt_id`, set `cnt` to 0, set `last` to the pick, go to BURST.
- Otherwise stay in IDLE.

BURST:
- `rdy` = `gnt_q` & {`NUM_REQ`{~`fifo_full`}}.
- Transfer when `|(rdy & req)`. On a transfer, `wr` = 1, `inputpixel` = the owner's slice, and `cnt` increments.
- The burst ends and the FSM returns to IDLE on any of:
  - a transfer with `cnt == BURST_LEN-1`;
  - a cycle where the owner has `req` low and `fifo_full` is 0 (owner idle, release);
  - never on `fifo_full` alone: the FSM stalls holding the grant.
- On burst end: `gnt_q` goes to 0, `burst_done` = 1 for the next cycle, `gnt_id` holds.

Combinational outputs and flags:
- `wr`, `rdy` and `inputpixel` are combinational from registered state plus `req`/`fifo_full`. All are forced to 0 while `rst_n` is 0.
- `inputpixel` is 0 when `wr` is 0.
- `err_ovf` sets on any cycle with `fifo_overflow` = 1 and clears only on reset.
- The arbiter never asserts `wr` with `fifo_full` = 1. `err_ovf` therefore flags external misuse of the FIFO only.

## Timing
Reset values: `state` = IDLE, `gnt_q` = 0, `gnt_id` = 0, `cnt` = 0, `last` = `NUM_REQ-1` (so producer 0 wins first), `burst_done` = 0, `err_ovf` = 0, `busy` = 0.

Cycle behaviour:
- Grant latency: `req` seen in IDLE at edge N gives `rdy` high in cycle N+1. The first pixel is written at edge N+2.
- A full burst is `BURST_LEN` consecutive writes if there is no stall.
- There is exactly one IDLE cycle between bursts. Sustained throughput is `BURST_LEN`/(`BURST_LEN`+1).
- Data path has zero-cycle latency: a pixel accepted in cycle K appears on `inputpixel` with `wr` = 1 in the same cycle K.
- `fifo_full` rising mid-burst: `rdy`/`wr` drop in the same cycle and `cnt` holds. The burst resumes when `fifo_full` falls.
- Owner `req` dropping while the FIFO is full: no release until the FIFO is not full.
- A request arriving during another's burst waits. Maximum wait is (`NUM_REQ`-1)·(`BURST_LEN`+1)+1 cycles with no FIFO stalls.
- Reset asserted mid-burst: at the next edge all registers take their reset values. Outputs are 0 during the low cycle. No partial `burst_done` pulse is emitted.

## Structure
- Shared package `pixel_pkg`:
  - `PIX_W` default;
  - `arb_state_t` enum {IDLE, BURST};
  - `FIFO_DEPTH` = 16.
- One sub-module, `rr_pick`: combinational round-robin priority picker. Inputs are `req` and `last`; outputs are a one-hot grant and its index. It is instantiated once.

## Test plan
- **Reset and first grant:** reset, then hold `req` = 4'b1111 with the FIFO never full. Required: `gnt_id` sequence 0,1,2,3,0. Each burst is 8 writes, followed by a `burst_done` pulse and one idle cycle.
- **Short burst:** producer 2 asserts `req` for 3 cycles only. Required: 3 writes with the correct pixels, release on the 4th cycle, `burst_done` the cycle after, `cnt` not carried into the next burst.
- **Full stall:** hold `fifo_full` = 1 for 5 cycles mid-burst at `cnt` = 4. Required: `wr` = 0 and `rdy` = 0 throughout, grant held, then 4 more writes after release, total 8.
- **Fairness:** producer 0 requests continuously and producer 3 requests once. Required: producer 3 is granted after at most one producer-0 burst.
- **Overflow flag:** pulse `fifo_overflow` for 1 cycle. Required: `err_ovf` = 1 and sticky until `rst_n` = 0 at an edge.
- **Reset mid-burst:** drop `rst_n` at `cnt` = 5. Required: `wr` = 0 immediately, all outputs at reset values after the edge, next grant goes to producer 0.
